// File: rtl/booth_mul16_seq.sv
// Sequential radix-2 Booth multiplier: WIDTH+1 add/sub-and-shift steps per product.
// Signed or unsigned operands selected per operation by `sign`.
module booth_mul16_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               sign,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH:0]       m_q, m_d;
    logic [WIDTH+1:0]     acc_q, acc_d;
    logic [WIDTH:0]       qr_q, qr_d;
    logic                 qm1_q, qm1_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic                 ov_q, ov_d;

    logic [WIDTH+1:0]     m_ext, sum, acc_sh;
    logic [WIDTH:0]       q_sh;

    // Guard bit keeps acc - M exact even for the most-negative M.
    always_comb begin
        m_ext = {m_q[WIDTH], m_q};
        sum   = acc_q;
        case ({qr_q[0], qm1_q})
            2'b01:   sum = acc_q + m_ext;
            2'b10:   sum = acc_q + ~m_ext + (WIDTH+2)'(1);
            default: sum = acc_q;
        endcase
        acc_sh = {sum[WIDTH+1], sum[WIDTH+1:1]};
        q_sh   = {sum[0], qr_q[WIDTH:1]};
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        qr_d    = qr_q;
        qm1_d   = qm1_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        ov_d    = ov_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    m_d     = sign ? {a[WIDTH-1], a} : {1'b0, a};
                    qr_d    = sign ? {b[WIDTH-1], b} : {1'b0, b};
                    acc_d   = '0;
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_sh;
                qr_d  = q_sh;
                qm1_d = qr_q[0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH)) begin
                    prod_d  = {acc_sh[WIDTH-2:0], q_sh};
                    ov_d    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    ov_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            qr_q    <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            qr_q    <= qr_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            ov_q    <= ov_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign out_valid = ov_q;
    assign product   = prod_q;

endmodule
